// File: rtl/conv_block_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// conv_block_sequencer_pkg
// Shared definitions for the column-block sequencer, the address FSM and the
// convolver: default widths, the default watchdog limit and the 3-bit
// sequencer state encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
package conv_block_sequencer_pkg;

  // Width of the block count and of the block index.
  localparam int NB_BLOCK_DEF = 10;

  // Width of the watchdog counter.
  localparam int NB_TIMEOUT_DEF = 16;

  // Maximum number of cycles the sequencer may sit in any wait state.
  localparam logic [15:0] TIMEOUT_DEF = 16'hFFFF;

  // Sequencer states; the encoding is shared with the address FSM and convolver.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_LWAIT = 3'd3,
    ST_PROC  = 3'd4,
    ST_PWAIT = 3'd5,
    ST_READ  = 3'd6,
    ST_DONE  = 3'd7
  } seq_state_e;

  // States in which the sequencer waits on the address FSM and the watchdog runs.
  function automatic logic is_wait_state(input seq_state_e st);
    logic wait_s;
    case (st)
      ST_LWAIT, ST_PWAIT, ST_READ: wait_s = 1'b1;
      default:                     wait_s = 1'b0;
    endcase
    return wait_s;
  endfunction

endpackage

// File: rtl/conv_block_sequencer_if.sv
// -----------------------------------------------------------------------------
// conv_block_sequencer_if
// Bundles the host commands, the address-FSM status/commands and the frame
// status of the column-block sequencer.
//   host -> sequencer : start, num_blocks, load_done, abort
//   addr FSM -> seq   : change_block, eop
//   seq -> addr FSM   : fsm_reset, load, sop
//   seq -> host       : block_idx, busy, done, error
// Modports: master = host / address-FSM side, slave = the sequencer.
// -----------------------------------------------------------------------------
interface conv_block_sequencer_if
  import conv_block_sequencer_pkg::*;
#(
  parameter int NB_BLOCK = NB_BLOCK_DEF
);

  logic                start;
  logic [NB_BLOCK-1:0] num_blocks;
  logic                load_done;
  logic                abort;
  logic                change_block;
  logic                eop;

  logic                fsm_reset;
  logic                load;
  logic                sop;
  logic [NB_BLOCK-1:0] block_idx;
  logic                busy;
  logic                done;
  logic                error;

  modport master (
    output start, num_blocks, load_done, abort, change_block, eop,
    input  fsm_reset, load, sop, block_idx, busy, done, error
  );

  modport slave (
    input  start, num_blocks, load_done, abort, change_block, eop,
    output fsm_reset, load, sop, block_idx, busy, done, error
  );

endinterface

// File: rtl/seq_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
// Counts cycles spent in a wait state of the block sequencer and flags the
// cycle in which the state has been occupied for TIMEOUT cycles.
// Ports:
//   i_CLK    in   clock
//   i_reset  in   synchronous active-high reset
//   clear    in   state change this cycle; restart the count
//   enable   in   the current state is a wait state
//   expired  out  this is the TIMEOUT-th consecutive cycle in the wait state
// -----------------------------------------------------------------------------
module seq_watchdog
  import conv_block_sequencer_pkg::*;
#(
  parameter int                    NB_TIMEOUT = NB_TIMEOUT_DEF,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT    = NB_TIMEOUT'(TIMEOUT_DEF)
) (
  input  logic i_CLK,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // count_r holds the number of cycles already completed in the state, so the
  // current cycle is number count_r+1; expiry therefore fires at TIMEOUT-1.
  localparam logic [NB_TIMEOUT-1:0] LAST_COUNT = TIMEOUT - 1'b1;

  logic [NB_TIMEOUT-1:0] count_r;

  assign expired = enable && (count_r == LAST_COUNT);

  // Cycle counter: restarts on a state change, saturates at expiry.
  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && !expired) begin
      count_r <= count_r + 1'b1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/conv_block_sequencer.sv
// -----------------------------------------------------------------------------
// conv_block_sequencer
// Walks a frame of column blocks through LOAD / PROC / READ phases by
// commanding the address FSM, with a watchdog on every wait state and a host
// abort. Timeout and abort both end the frame with a sticky error and a
// reset pulse to the address FSM, and never with a done pulse.
// Ports:
//   i_CLK    in   clock
//   i_reset  in   synchronous active-high reset, highest priority
//   bus      slave modport of conv_block_sequencer_if
//            start/num_blocks/load_done/abort  host commands
//            change_block/eop                  address FSM status
//            fsm_reset/load/sop                address FSM commands (registered)
//            block_idx/busy/done/error         frame status (registered)
// -----------------------------------------------------------------------------
module conv_block_sequencer
  import conv_block_sequencer_pkg::*;
#(
  parameter int                    NB_BLOCK   = NB_BLOCK_DEF,
  parameter int                    NB_TIMEOUT = NB_TIMEOUT_DEF,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT    = NB_TIMEOUT'(TIMEOUT_DEF)
) (
  input  logic                  i_CLK,
  input  logic                  i_reset,
  conv_block_sequencer_if.slave bus
);

  seq_state_e          state_r;
  seq_state_e          state_s;
  logic [NB_BLOCK-1:0] count_r;
  logic [NB_BLOCK-1:0] count_s;
  logic [NB_BLOCK-1:0] block_idx_r;
  logic [NB_BLOCK-1:0] block_idx_s;
  logic                eop_prev_r;

  logic                fsm_reset_r;
  logic                fsm_reset_s;
  logic                load_r;
  logic                load_s;
  logic                sop_r;
  logic                sop_s;
  logic                busy_r;
  logic                busy_s;
  logic                done_r;
  logic                done_s;
  logic                error_r;
  logic                error_s;

  logic                eop_rise_s;
  logic                last_block_s;
  logic                kill_s;
  logic                wd_clear_s;
  logic                wd_enable_s;
  logic                wd_expired_s;

  assign eop_rise_s   = bus.eop && !eop_prev_r;
  // count_r is never zero while a frame runs, so count_r-1 cannot underflow.
  assign last_block_s = (block_idx_r == (count_r - 1'b1));
  assign wd_enable_s  = is_wait_state(state_r);
  assign wd_clear_s   = (state_s != state_r);
  // Abort and timeout share one exit path and beat any completion event.
  assign kill_s       = (state_r != ST_IDLE) && (bus.abort || wd_expired_s);

  seq_watchdog #(
    .NB_TIMEOUT (NB_TIMEOUT),
    .TIMEOUT    (TIMEOUT)
  ) u_watchdog (
    .i_CLK   (i_CLK),
    .i_reset (i_reset),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .expired (wd_expired_s)
  );

  // Next-state, frame bookkeeping and next values of the registered outputs.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    block_idx_s = block_idx_r;
    error_s     = error_r;
    done_s      = 1'b0;

    if (kill_s) begin
      state_s = ST_IDLE;
      error_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.num_blocks != '0) begin
              count_s     = bus.num_blocks;
              block_idx_s = '0;
              error_s     = 1'b0;
              state_s     = ST_INIT;
            end else begin
              // Empty frame: report completion without leaving IDLE.
              done_s = 1'b1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_INIT: begin
          state_s = ST_LOAD;
        end
        ST_LOAD: begin
          if (bus.load_done) begin
            state_s = ST_LWAIT;
          end else begin
            state_s = ST_LOAD;
          end
        end
        ST_LWAIT: begin
          if (bus.change_block) begin
            state_s = ST_PROC;
          end else begin
            state_s = ST_LWAIT;
          end
        end
        ST_PROC: begin
          state_s = ST_PWAIT;
        end
        ST_PWAIT: begin
          // change_block is deliberately not looked at here.
          if (eop_rise_s) begin
            state_s = ST_READ;
          end else begin
            state_s = ST_PWAIT;
          end
        end
        ST_READ: begin
          if (bus.change_block) begin
            if (last_block_s) begin
              state_s = ST_DONE;
            end else begin
              block_idx_s = block_idx_r + 1'b1;
              state_s     = ST_LOAD;
            end
          end else begin
            state_s = ST_READ;
          end
        end
        ST_DONE: begin
          // done is raised on the way out so an abort in DONE can still veto it.
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end

    // Commands follow the state being entered, so load and sop are exclusive.
    fsm_reset_s = kill_s || (state_s == ST_INIT);
    load_s      = (state_s == ST_LOAD);
    sop_s       = (state_s == ST_PROC);
    busy_s      = (state_s != ST_IDLE);
  end

  // State register plus frame count, block index and EoP history.
  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      block_idx_r <= '0;
      eop_prev_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      block_idx_r <= block_idx_s;
      eop_prev_r  <= bus.eop;
    end
  end

  // Output registers.
  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      fsm_reset_r <= 1'b0;
      load_r      <= 1'b0;
      sop_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      fsm_reset_r <= fsm_reset_s;
      load_r      <= load_s;
      sop_r       <= sop_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      error_r     <= error_s;
    end
  end

  assign bus.fsm_reset = fsm_reset_r;
  assign bus.load      = load_r;
  assign bus.sop       = sop_r;
  assign bus.block_idx = block_idx_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.error     = error_r;

endmodule
